ysyx_23060184_ifu: RTL

//  Instruction fetch stage, directly upstream of the decode stage. Holds the PC, issues one word

---
 rtl/ysyx_23060184_ifu_pkg.sv | 41 ++++
 rtl/ysyx_23060184_ifu_if.sv | 42 ++++
 rtl/ysyx_23060184_ifu_perf.sv | 43 ++++
 rtl/ysyx_23060184_ifu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_ifu_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_23060184_ifu_pkg
//   Shared definitions for the instruction fetch unit:
//     `DATA_WIDTH / IFU_DATA_WIDTH : inst / PC / address width
//     `IFU_NOP    / IFU_NOP        : canonical NOP (addi x0, x0, 0)
//     IFU_S_*                      : 2-bit fetch FSM state encoding
//     ifu_state_e                  : typed view of the state encoding
//     word_align()                 : clears the two byte-offset bits of an address
//   No ports (package).
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef IFU_NOP
`define IFU_NOP 32'h0000_0013
`endif

package ysyx_23060184_ifu_pkg;

   localparam int          IFU_DATA_WIDTH = `DATA_WIDTH;
   localparam logic [31:0] IFU_NOP        = `IFU_NOP;

   localparam logic [1:0] IFU_S_REQ  = 2'd0;
   localparam logic [1:0] IFU_S_WAIT = 2'd1;
   localparam logic [1:0] IFU_S_HOLD = 2'd2;
   localparam logic [1:0] IFU_S_NEXT = 2'd3;

   typedef enum logic [1:0] {
      S_REQ  = IFU_S_REQ,   // request presented, waiting for req_ready
      S_WAIT = IFU_S_WAIT,  // request accepted, waiting for the response
      S_HOLD = IFU_S_HOLD,  // instruction presented to decode
      S_NEXT = IFU_S_NEXT   // waiting for writeback to supply the next PC
   } ifu_state_e;

   // Fetches are always whole words, so the byte offset is discarded.
   function automatic logic [IFU_DATA_WIDTH-1:0] word_align(input logic [IFU_DATA_WIDTH-1:0] addr);
      return {addr[IFU_DATA_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_23060184_ifu_if.sv
// -----------------------------------------------------------------------------
// ysyx_23060184_ifu_if
//   Instruction-memory bus between the IFU (master) and the memory (slave).
//   Request channel : imem_req_valid, imem_req_ready, imem_addr
//   Response channel: imem_rsp_valid, imem_rsp_ready, imem_rsp_data, imem_rsp_err
//   Modports:
//     master - IFU side: drives req_valid/addr/rsp_ready
//     slave  - memory side: drives req_ready/rsp_valid/rsp_data/rsp_err
// -----------------------------------------------------------------------------
interface ysyx_23060184_ifu_if
   import ysyx_23060184_ifu_pkg::*;
();

   logic                      imem_req_valid;
   logic                      imem_req_ready;
   logic [IFU_DATA_WIDTH-1:0] imem_addr;
   logic                      imem_rsp_valid;
   logic                      imem_rsp_ready;
   logic [IFU_DATA_WIDTH-1:0] imem_rsp_data;
   logic                      imem_rsp_err;

   modport master (
      output imem_req_valid,
      input  imem_req_ready,
      output imem_addr,
      input  imem_rsp_valid,
      output imem_rsp_ready,
      input  imem_rsp_data,
      input  imem_rsp_err
   );

   modport slave (
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_addr,
      output imem_rsp_valid,
      input  imem_rsp_ready,
      output imem_rsp_data,
      output imem_rsp_err
   );

endinterface

// File: rtl/ysyx_23060184_ifu_perf.sv
// -----------------------------------------------------------------------------
// ysyx_23060184_ifu_perf
//   Two free-running 64-bit event counters for the IFU. Each counts one per
//   cycle its enable is high, wraps modulo 2^64, and clears on reset.
//   Ports:
//     clk          in   1   clock
//     rstn         in   1   synchronous active-low reset
//     fetch_inc_i  in   1   an instruction response was accepted this cycle
//     stall_inc_i  in   1   the IFU is waiting on memory this cycle
//     fetch_cnt_o  out  64  accepted-response count
//     stall_cnt_o  out  64  memory-wait cycle count
// -----------------------------------------------------------------------------
module ysyx_23060184_ifu_perf (
   input  logic        clk,
   input  logic        rstn,
   input  logic        fetch_inc_i,
   input  logic        stall_inc_i,
   output logic [63:0] fetch_cnt_o,
   output logic [63:0] stall_cnt_o
);

   logic [63:0] fetch_cnt_q, fetch_cnt_d;
   logic [63:0] stall_cnt_q, stall_cnt_d;

   assign fetch_cnt_d = fetch_inc_i ? fetch_cnt_q + 64'd1 : fetch_cnt_q;
   assign stall_cnt_d = stall_inc_i ? stall_cnt_q + 64'd1 : stall_cnt_q;

   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ysyx_23060184_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_23060184_ifu
//   Instruction fetch stage of a multi-cycle, single-issue core. Holds the PC,
//   issues one word fetch per instruction over the imem valid/ready bus, and
//   presents inst+pc to decode under Ivalid. The next fetch starts only after
//   writeback returns the next PC on npc_valid; the IFU never increments the
//   PC itself.
//
//   Optional feature: define IFU_PERF_EN to build the fetch/stall counters;
//   otherwise perf_fetch_cnt / perf_stall_cnt are tied to zero.
//
//   Ports:
//     clk             in   1    clock
//     rstn            in   1    synchronous active-low reset
//     npc_valid       in   1    writeback presents the next PC
//     npc             in   DW   next PC from writeback
//     imem            if        instruction-memory bus (master modport)
//     inst            out  DW   instruction to decode (NOP after a fault)
//     pc              out  DW   PC of inst
//     Ivalid          out  1    inst/pc valid to decode
//     Dready          in   1    decode accepts inst
//     fetch_err       out  1    qualifies Ivalid: inst came from a faulting access
//     perf_fetch_cnt  out  64   accepted-response count
//     perf_stall_cnt  out  64   cycles spent in S_REQ or S_WAIT
// -----------------------------------------------------------------------------
module ysyx_23060184_ifu
   import ysyx_23060184_ifu_pkg::*;
#(
   parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  npc_valid,
   input  logic [DATA_WIDTH-1:0] npc,
   ysyx_23060184_ifu_if.master   imem,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [DATA_WIDTH-1:0] pc,
   output logic                  Ivalid,
   input  logic                  Dready,
   output logic                  fetch_err,
   output logic [63:0]           perf_fetch_cnt,
   output logic [63:0]           perf_stall_cnt
);

   ifu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] inst_q, inst_d;
   logic                  ivalid_q, ivalid_d;
   logic                  fetch_err_q, fetch_err_d;

   logic                  req_valid;
   logic                  rsp_ready;
   logic                  rsp_fire;

   // A response only counts while we are waiting for it; anything the memory
   // presents in another state is left on the bus, unconsumed.
   assign rsp_fire = (state_q == S_WAIT) && imem.imem_rsp_valid;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         inst_q      <= IFU_NOP;
         ivalid_q    <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         ivalid_q    <= ivalid_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // NOTE: every signal written here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      ivalid_d    = ivalid_q;
      fetch_err_d = fetch_err_q;
      req_valid   = 1'b0;
      rsp_ready   = 1'b0;

      unique case (state_q)
         S_REQ: begin
            // Held with a stable address until the memory takes it.
            req_valid = 1'b1;
            if (imem.imem_req_ready) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            rsp_ready = 1'b1;
            if (rsp_fire) begin
               // A faulting word is never handed to decode as an instruction.
               inst_d      = imem.imem_rsp_err ? IFU_NOP : imem.imem_rsp_data;
               fetch_err_d = imem.imem_rsp_err;
               ivalid_d    = 1'b1;
               state_d     = S_HOLD;
            end
         end

         S_HOLD: begin
            if (ivalid_q && Dready) begin
               ivalid_d = 1'b0;
               state_d  = S_NEXT;
            end
         end

         S_NEXT: begin
            // Writeback has already resolved branches/traps; just realign.
            if (npc_valid) begin
               pc_d    = word_align(npc);
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_addr      = word_align(pc_q);
   assign imem.imem_rsp_ready = rsp_ready;

   assign inst      = inst_q;
   assign pc        = pc_q;
   assign Ivalid    = ivalid_q;
   assign fetch_err = fetch_err_q;

`ifdef IFU_PERF_EN
   ysyx_23060184_ifu_perf u_perf (
      .clk         (clk),
      .rstn        (rstn),
      .fetch_inc_i (rsp_fire),
      .stall_inc_i ((state_q == S_REQ) || (state_q == S_WAIT)),
      .fetch_cnt_o (perf_fetch_cnt),
      .stall_cnt_o (perf_stall_cnt)
   );
`else
   assign perf_fetch_cnt = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule
